// File: rtl/mem_subsystem_if.sv
// Core-to-memory request/response bus (MAR/MDR side).
interface mem_subsystem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
);
  logic              req_read;
  logic              req_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;

  // Core side issues requests and watches busy/done.
  modport master (
    output req_read, req_write, addr, wdata,
    input  rdata, busy, done
  );

  // Memory side accepts requests and returns completion.
  modport slave (
    input  req_read, req_write, addr, wdata,
    output rdata, busy, done
  );
endinterface

// File: rtl/mem_subsystem.sv
// Handshaked word RAM with programmable wait states and one memory-mapped I/O word.
// Optional feature macro: MEM_PARITY_EN (stores an even-parity bit per RAM word,
// pulses err with done on a RAM read whose stored parity disagrees with the data).
module mem_subsystem #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned IO_ADDR     = 511
) (
  input  logic              clk,
  input  logic              reset,
  mem_subsystem_if.slave    bus,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [MEM_W-1:0]  mem [0:DEPTH-1];

  logic              is_io_c;
  logic              is_ram_c;
  logic [IDX_W-1:0]  idx_c;
  logic [MEM_W-1:0]  ram_word_c;

  // Decode the latched address; the I/O word shadows any RAM word at the same address.
  assign is_io_c    = (lat_addr == ADDR_W'(IO_ADDR));
  assign is_ram_c   = !is_io_c && (32'(lat_addr) < 32'(DEPTH));
  assign idx_c      = lat_addr[IDX_W-1:0];
  assign ram_word_c = mem[idx_c];

  // Request FSM: accept in IDLE, count wait states, perform the access and pulse done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      out_port  <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.busy <= (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.req_write || bus.req_read) begin
            op_write  <= bus.req_write;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            cnt       <= CNT_W'(WAIT_STATES);
            state     <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_ACCESS;
        end
        S_ACCESS: begin
          bus.done <= 1'b1;
          if (op_write) begin
            if (is_io_c) out_port <= lat_wdata;
          end else if (is_io_c) begin
            bus.rdata <= in_port;
          end else if (is_ram_c) begin
            bus.rdata <= ram_word_c[DATA_W-1:0];
          end else begin
            bus.rdata <= '0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && op_write && is_ram_c) begin
`ifdef MEM_PARITY_EN
      mem[idx_c] <= {^lat_wdata, lat_wdata};
`else
      mem[idx_c] <= lat_wdata;
`endif
    end
  end

`ifdef MEM_PARITY_EN
  // Parity check on RAM reads, timed to coincide with done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else        err <= (state == S_ACCESS) && !op_write && is_ram_c &&
                       (ram_word_c[DATA_W] != ^ram_word_c[DATA_W-1:0]);
  end
`else
  assign err = 1'b0;
`endif

endmodule
